// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: opcodes, forwarding selects and the
// hazard scheduler's shadow-slot payloads.
package rv32_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_STALL,
    MODE_FLUSH,
    MODE_FREEZE
  } sched_mode_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             load;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             u1;
    logic             u2;
  } ex_slot_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
  } retire_slot_t;

  function automatic retire_slot_t to_retire(input ex_slot_t s);
    retire_slot_t r;
    r.valid = s.valid;
    r.rd    = s.rd;
    r.wr    = s.wr;
    return r;
  endfunction

  // MEM is the younger producer, so it takes priority over WB.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_W-1:0] src,
                                         input retire_slot_t mem, input retire_slot_t wb);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src && mem.valid && mem.wr && (mem.rd == src)) begin
      sel = FWD_MEM;
    end else if (use_src && wb.valid && wb.wr && (wb.rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard scheduler bundle: ID/EX/MEM status in, enables,
// flushes, forwarding selects and perf counters out.
interface hazard_ctrl_if
  import rv32_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic [XLEN-1:0]  id_instr32;
  logic             id_valid;
  logic             ex_taken;
  logic             dmem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_instr32, id_valid, ex_taken, dmem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_instr32, id_valid, ex_taken, dmem_busy,
    output pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_decode.sv
// Combinational ID-stage field and register-usage decode for the hazard
// scheduler; all flags are forced low for a bubble.
module hazard_decode
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0]  instr,
  input  logic             valid,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output logic             u1,
  output logic             u2,
  output logic             wr,
  output logic             load
);

  logic op_u1;
  logic op_u2;
  logic op_wr;
  logic op_load;
  logic unused_fields;

  assign unused_fields = ^{instr[31:25], instr[14:12]};

  always_comb begin
    op_u1   = 1'b0;
    op_u2   = 1'b0;
    op_wr   = 1'b0;
    op_load = 1'b0;
    case (instr[6:0])
      OP_LOAD:   begin op_u1 = 1'b1; op_wr = 1'b1; op_load = 1'b1; end
      OP_IMM:    begin op_u1 = 1'b1; op_wr = 1'b1; end
      OP_AUIPC:  op_wr = 1'b1;
      OP_STORE:  begin op_u1 = 1'b1; op_u2 = 1'b1; end
      OP_REG:    begin op_u1 = 1'b1; op_u2 = 1'b1; op_wr = 1'b1; end
      OP_LUI:    op_wr = 1'b1;
      OP_BRANCH: begin op_u1 = 1'b1; op_u2 = 1'b1; end
      OP_JALR:   begin op_u1 = 1'b1; op_wr = 1'b1; end
      OP_JAL:    op_wr = 1'b1;
      default:   ;
    endcase
  end

  assign rs1  = instr[19:15];
  assign rs2  = instr[24:20];
  assign rd   = instr[11:7];
  assign u1   = valid & op_u1;
  assign u2   = valid & op_u2;
  // x0 writes are architectural no-ops and must never become a forward source.
  assign wr   = valid & op_wr & (instr[11:7] != REG_W'(0));
  assign load = valid & op_load;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage RV32I hazard scheduler: load-use stalls, taken-branch squashes,
// dmem freezes, EX operand forwarding and saturating perf counters.
module hazard_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave bus
);

  logic [REG_W-1:0] dec_rs1;
  logic [REG_W-1:0] dec_rs2;
  logic [REG_W-1:0] dec_rd;
  logic             dec_u1;
  logic             dec_u2;
  logic             dec_wr;
  logic             dec_load;

  ex_slot_t         id_slot;
  ex_slot_t         ex_q, ex_d;
  retire_slot_t     mem_q, mem_d;
  retire_slot_t     wb_q, wb_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  sched_mode_e      mode;
  logic             load_use;
  logic             pc_en, ifid_en, ifid_flush, idex_flush;

  hazard_decode u_decode (
    .instr (bus.id_instr32),
    .valid (bus.id_valid),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2),
    .rd    (dec_rd),
    .u1    (dec_u1),
    .u2    (dec_u2),
    .wr    (dec_wr),
    .load  (dec_load)
  );

  always_comb begin
    id_slot       = '0;
    id_slot.valid = bus.id_valid;
    id_slot.rd    = dec_rd;
    id_slot.wr    = dec_wr;
    id_slot.load  = dec_load;
    id_slot.rs1   = dec_rs1;
    id_slot.rs2   = dec_rs2;
    id_slot.u1    = dec_u1;
    id_slot.u2    = dec_u2;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign load_use = ex_q.valid & ex_q.load & ex_q.wr &
                    ((dec_u1 & (dec_rs1 == ex_q.rd)) | (dec_u2 & (dec_rs2 == ex_q.rd)));

  // Freeze beats flush (EX holds, so the taken branch is re-presented), flush beats stall.
  always_comb begin
    mode = MODE_NORMAL;
    if (bus.dmem_busy) begin
      mode = MODE_FREEZE;
    end else if (bus.ex_taken) begin
      mode = MODE_FLUSH;
    end else if (load_use) begin
      mode = MODE_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    ex_d       = ex_q;
    mem_d      = mem_q;
    wb_d       = wb_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (mode)
      MODE_NORMAL: begin
        ex_d  = id_slot;
        mem_d = to_retire(ex_q);
        wb_d  = mem_q;
      end
      MODE_STALL: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        ex_d       = '0;
        mem_d      = to_retire(ex_q);
        wb_d       = mem_q;
        stall_d    = sat_inc(stall_q);
      end
      MODE_FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        ex_d       = '0;
        mem_d      = to_retire(ex_q);
        wb_d       = mem_q;
        flush_d    = sat_inc(flush_q);
      end
      MODE_FREEZE: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
      end
      default: ;
    endcase
    // Hold the front end in bubbles for as long as reset is asserted.
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.fwd_a      = ex_q.valid ? fwd_sel(ex_q.u1, ex_q.rs1, mem_q, wb_q) : FWD_RF;
  assign bus.fwd_b      = ex_q.valid ? fwd_sel(ex_q.u2, ex_q.rs2, mem_q, wb_q) : FWD_RF;
  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed instruction streams push expected
// control outputs; a monitor pops and compares each cycle.
module tb_hazard_ctrl;
  import rv32_pkg::*;

  localparam logic [31:0] LW5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD6  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] ADDI3 = 32'h00100193; // addi x3,x0,1
  localparam logic [31:0] ADDI4 = 32'h00200213; // addi x4,x0,2
  localparam logic [31:0] ADD7  = 32'h004183B3; // add  x7,x3,x4
  localparam logic [31:0] ADDI0 = 32'h00500013; // addi x0,x0,5
  localparam logic [31:0] ADD1  = 32'h000000B3; // add  x1,x0,x0
  localparam logic [31:0] LUI5  = 32'h000012B7; // lui  x5,1

  // {pc_en, ifid_en, ifid_flush, idex_flush}
  localparam logic [3:0] C_N = 4'b1100;
  localparam logic [3:0] C_S = 4'b0001;
  localparam logic [3:0] C_F = 4'b1111;
  localparam logic [3:0] C_Z = 4'b0000;
  localparam logic [3:0] C_R = 4'b0011;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] s;
    logic [15:0] f;
    logic        sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) bus_a ();
  hazard_ctrl_if #(.CNT_W(2))  bus_b ();

  hazard_ctrl #(.CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  hazard_ctrl #(.CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  function automatic exp_t mk(input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                              input int s, input int f, input logic sel);
    exp_t e;
    e.ctl = ctl;
    e.fa  = fa;
    e.fb  = fb;
    e.s   = 16'(s);
    e.f   = 16'(f);
    e.sel = sel;
    return e;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic drive(input logic [31:0] instr, input logic v, input logic tk, input logic bz);
    bus_a.id_instr32 = instr;
    bus_a.id_valid   = v;
    bus_a.ex_taken   = tk;
    bus_a.dmem_busy  = bz;
    bus_b.id_instr32 = instr;
    bus_b.id_valid   = v;
    bus_b.ex_taken   = tk;
    bus_b.dmem_busy  = bz;
  endtask

  task automatic step(input logic [31:0] instr, input logic v, input logic tk, input logic bz,
                      input exp_t e, input string nm);
    @(posedge clk);
    #1;
    drive(instr, v, tk, bz);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare once per cycle, and immediately on an asynchronous reset.
  initial begin
    exp_t  e;
    exp_t  act;
    string nm;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.sel) begin
          act.ctl = {bus_b.pc_en, bus_b.ifid_en, bus_b.ifid_flush, bus_b.idex_flush};
          act.fa  = bus_b.fwd_a;
          act.fb  = bus_b.fwd_b;
          act.s   = 16'(bus_b.stall_cnt);
          act.f   = 16'(bus_b.flush_cnt);
        end else begin
          act.ctl = {bus_a.pc_en, bus_a.ifid_en, bus_a.ifid_flush, bus_a.idex_flush};
          act.fa  = bus_a.fwd_a;
          act.fb  = bus_a.fwd_b;
          act.s   = bus_a.stall_cnt;
          act.f   = bus_a.flush_cnt;
        end
        act.sel = e.sel;
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got ctl=%b fa=%b fb=%b stall=%0d flush=%0d, expected ctl=%b fa=%b fb=%b stall=%0d flush=%0d",
                   nm, act.ctl, act.fa, act.fb, act.s, act.f, e.ctl, e.fa, e.fb, e.s, e.f);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 1'b0, mk(C_R, FWD_RF, FWD_RF, 0, 0, 1'b0), "reset_values");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // load-use stall, then WB forward of the loaded value
    step(LW5,   1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 0, 0, 1'b0), "c1_lw");
    step(ADD6,  1'b1, 1'b0, 1'b0, mk(C_S, FWD_RF, FWD_RF, 0, 0, 1'b0), "c2_loaduse_stall");
    step(ADD6,  1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 0, 1'b0), "c3_resume");
    step(32'h0, 1'b0, 1'b0, 1'b0, mk(C_N, FWD_WB, FWD_RF, 1, 0, 1'b0), "c4_fwd_wb_load");
    // MEM/WB forwarding
    step(ADDI3, 1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 0, 1'b0), "c5_addi3");
    step(ADDI4, 1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 0, 1'b0), "c6_addi4");
    step(ADD7,  1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 0, 1'b0), "c7_add7");
    step(32'h0, 1'b0, 1'b0, 1'b0, mk(C_N, FWD_WB, FWD_MEM, 1, 0, 1'b0), "c8_fwd_wb_mem");
    // x0 is never a forward source; non-users never stall
    step(ADDI0, 1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 0, 1'b0), "c9_addi_x0");
    step(ADD1,  1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 0, 1'b0), "c10_add_x0");
    step(32'h0, 1'b0, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 0, 1'b0), "c11_no_fwd_x0");
    step(LW5,   1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 0, 1'b0), "c12_lw");
    step(LUI5,  1'b1, 1'b0, 1'b0, mk(C_N, FWD_WB, FWD_RF, 1, 0, 1'b0), "c13_lui_no_stall");
    step(32'h0, 1'b0, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 0, 1'b0), "c14_lui_in_ex");
    // taken branch overrides a pending load-use stall
    step(LW5,   1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 0, 1'b0), "c15_lw");
    step(ADD6,  1'b1, 1'b1, 1'b0, mk(C_F, FWD_RF, FWD_RF, 1, 0, 1'b0), "c16_flush_over_stall");
    step(32'h0, 1'b0, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 1, 1'b0), "c17_after_flush");
    // freeze with a pending taken branch; forwarding stays live
    step(ADDI3, 1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 1, 1'b0), "c18_addi3");
    step(ADD7,  1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 1, 1'b0), "c19_add7");
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 1'b0, 1'b1, 1'b1, mk(C_Z, FWD_MEM, FWD_RF, 1, 1, 1'b0), "c20_freeze");
    end
    step(32'h0, 1'b0, 1'b1, 1'b0, mk(C_F, FWD_MEM, FWD_RF, 1, 1, 1'b0), "c23_flush_after_freeze");
    step(32'h0, 1'b0, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 2, 1'b0), "c24_idle");
    // asynchronous reset in the middle of a stall
    step(LW5,   1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 1, 2, 1'b0), "c25_lw");
    step(ADD6,  1'b1, 1'b0, 1'b0, mk(C_S, FWD_RF, FWD_RF, 1, 2, 1'b0), "c26_stall");
    @(negedge clk);
    #2;
    exp_q.push_back(mk(C_R, FWD_RF, FWD_RF, 0, 0, 1'b0));
    name_q.push_back("reset_async");
    rst_n = 1'b0;
    step(ADD6,  1'b1, 1'b0, 1'b0, mk(C_R, FWD_RF, FWD_RF, 0, 0, 1'b0), "c27_reset_hold");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step(ADD6,  1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 0, 0, 1'b0), "c28_post_reset");
    step(32'h0, 1'b0, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, 0, 0, 1'b0), "c29_idle");
    // saturation on the 2-bit instance: five stalls end at 3
    for (int k = 1; k <= 5; k++) begin
      step(LW5,  1'b1, 1'b0, 1'b0, mk(C_N, (k == 1) ? FWD_RF : FWD_WB, FWD_RF, sat3(k - 1), 0, 1'b1), "sat_lw");
      step(ADD6, 1'b1, 1'b0, 1'b0, mk(C_S, FWD_RF, FWD_RF, sat3(k - 1), 0, 1'b1), "sat_stall");
      step(ADD6, 1'b1, 1'b0, 1'b0, mk(C_N, FWD_RF, FWD_RF, sat3(k), 0, 1'b1), "sat_resume");
    end
    step(32'h0, 1'b0, 1'b0, 1'b0, mk(C_N, FWD_WB, FWD_RF, 3, 0, 1'b1), "sat_final");

    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline scheduler for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Decodes the instruction in ID and keeps its own shadow of the destination/source registers of the EX, MEM and WB stages.
- From these it drives PC/IF-ID enables, stage flushes and EX operand forwarding selects.
- Handles three events: load-use stalls, taken branch/jump squashes, and data-memory wait freezes.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_instr32  in  32  instruction word currently in the ID stage.
- id_valid  in  1  id_instr32 is a real instruction, not a bubble.
- ex_taken  in  1  branch or jump in EX resolved taken this cycle.
- dmem_busy  in  1  data memory has not completed the MEM-stage access; freeze the pipeline.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  load a bubble into IF/ID.
- idex_flush  out  1  load a bubble into ID/EX.
- fwd_a  out  2  EX operand A select: 00 = register file, 10 = MEM result, 01 = WB result.
- fwd_b  out  2  EX operand B select; same encoding as fwd_a.
- stall_cnt  out  CNT_W  number of load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  number of taken-branch flush cycles, saturating.

Behaviour:

ID decode (combinational):
- rs1 = [19:15], rs2 = [24:20], rd = [11:7], opcode = [6:0].
- uses_rs1: every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
- uses_rs2: R 0110011, S 0100011 and B 1100011 only.
- writes_rd: LOAD, OP-IMM, AUIPC, OP, LUI, JALR and JAL, and only when rd != 0.
- is_load: opcode 0000011.
- An unknown opcode decodes to no uses and no write.
- All decode flags are gated by id_valid.

Shadow slots:
- ex_slot = {valid, rd, wr, load, rs1, rs2, u1, u2}.
- mem_slot and wb_slot = {valid, rd, wr}.
- On reset all valid bits are 0.

Priority per cycle, highest first:
1. Freeze (dmem_busy = 1):
   - pc_en = 0, ifid_en = 0, ifid_flush = 0, idex_flush = 0.
   - All slots hold; counters hold.
2. Flush (ex_taken = 1):
   - pc_en = 1, ifid_en = 1, ifid_flush = 1, idex_flush = 1.
   - ex_slot becomes a bubble, mem_slot takes ex_slot, wb_slot takes mem_slot.
   - flush_cnt increments.
   - Flush overrides any load-use stall, because the stalled instruction is squashed anyway.
3. Load-use stall:
   - Condition: ex_slot.valid & ex_slot.load & ex_slot.wr & ((u1 & rs1 == ex_slot.rd) | (u2 & rs2 == ex_slot.rd)), where u1/u2/rs1/rs2 are the ID decode results.
   - pc_en = 0, ifid_en = 0, ifid_flush = 0, idex_flush = 1.
   - ex_slot becomes a bubble; mem and wb advance.
   - stall_cnt increments.
4. Normal:
   - pc_en = 1, ifid_en = 1, both flushes 0.
   - ex_slot takes the ID decode; mem and wb advance.

Forwarding (combinational, from the slots):
- fwd_a = 10 if ex_slot.u1 & mem_slot.valid & mem_slot.wr & mem_slot.rd == ex_slot.rs1.
- Otherwise fwd_a = 01 if the same test passes against wb_slot.
- Otherwise fwd_a = 00.
- MEM wins over WB. fwd_b is identical using u2/rs2.
- A bubble in ex_slot gives 00.
- Forwarding is computed during a freeze as well.
- A load sitting in MEM is never forwarded from MEM: the load-use stall guarantees it reaches WB first.
- x0 is never forwarded, since wr is 0 when rd == 0.

Counters:
- Saturate at all ones.
- Reset to 0.

Reset:
- While rst_n = 0: pc_en = 0, ifid_en = 0, ifid_flush = 1, idex_flush = 1, fwd_a = fwd_b = 00, counters 0, slots invalid.
- Asserting reset mid-stall or mid-freeze discards all state.
- The first cycle after release is a Normal cycle with empty slots.

Simultaneous events:
- dmem_busy together with ex_taken: freeze. The EX stage holds, so ex_taken is re-presented once dmem_busy drops.
- id_valid = 0: never stalls, and loads a bubble into ex_slot.

Latency:
- All control outputs are combinational in the current inputs and slots; no cycle delay.
- Slots update on the rising edge.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, reused by the decode logic;
  - the forwarding select constants FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10.
- One sub-module: hazard_decode, the combinational ID field/usage decode (rs1, rs2, rd, u1, u2, wr, load).
- Slot registers, priority logic and counters stay in hazard_ctrl.

Test Plan:
- Load-use:
  - Stimulus: lw x5,0(x1) (0x0000A283), then add x6,x5,x2 (0x00228333).
  - Required: on the add cycle, pc_en = 0, ifid_en = 0, idex_flush = 1, stall_cnt = 1.
  - Next cycle: no stall, fwd_a = 01.
- MEM/WB forwarding:
  - Stimulus: addi x3,x0,1; addi x4,x0,2; add x7,x3,x4, back to back.
  - Required: with add in EX, fwd_a = 01 and fwd_b = 10.
- x0 and non-users:
  - Stimulus: addi x0,x0,5 followed by add x1,x0,x0.
  - Required: fwd_a = fwd_b = 00.
  - Stimulus: lw x5 followed by lui x5,1.
  - Required: no stall.
- Taken branch:
  - Stimulus: ex_taken = 1 for one cycle while ID holds a dependent instruction of a preceding lw.
  - Required: ifid_flush = idex_flush = 1, pc_en = 1, flush_cnt = 1, stall_cnt unchanged.
- Freeze:
  - Stimulus: dmem_busy = 1 for 3 cycles with ex_taken = 1.
  - Required: all enables and flushes 0 and counters hold for those cycles.
  - On the cycle after release: flush asserted.
- Reset and saturation:
  - Stimulus: pull rst_n low mid-stall.
  - Required: outputs take their reset values immediately (asynchronously).
  - Stimulus: with CNT_W = 2, apply 5 stalls.
  - Required: stall_cnt = 3.
